// File: rtl/adc_sample_avg.sv
// Windowed average / min / max of XADC DRP samples with a single-entry
// valid/ready result register and a sticky overrun flag.
module adc_sample_avg #(
    parameter int          LOG2_N = 4,
    parameter logic [11:0] THRESH = 12'hC00
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        en_i,
    input  logic        drdy_i,
    input  logic [15:0] data_i,
    output logic [11:0] avg_o,
    output logic [11:0] min_o,
    output logic [11:0] max_o,
    output logic        over_o,
    output logic        avg_valid_o,
    input  logic        avg_ready_i,
    output logic        overrun_o
);

    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + LOG2_N;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);
    localparam logic [DATA_W-1:0] MIN_INIT = '1;
    localparam logic [DATA_W-1:0] MAX_INIT = '0;

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> LOG2_N);
    endfunction

    function automatic logic [DATA_W-1:0] min_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    logic [0:0]        state_q;
    logic [ACC_W-1:0]  acc_p0;
    logic [LOG2_N-1:0] cnt_p0;
    logic [DATA_W-1:0] min_p0;
    logic [DATA_W-1:0] max_p0;
    logic              vld_p1;
    logic              ovr_p1;

    logic [DATA_W-1:0] sample;
    logic [ACC_W-1:0]  sum_next;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] avg_next;
    logic              start;
    logic              take;
    logic              last;
    logic              xfer;
    logic              unused_nibble;

    assign sample        = data_i[15:4];
    assign unused_nibble = ^data_i[3:0];

    assign start    = (state_q == IDLE) && en_i;
    assign take     = (state_q == RUN) && en_i && drdy_i;
    assign last     = take && (cnt_p0 == CNT_LAST);
    assign xfer     = vld_p1 && avg_ready_i;

    // Accumulator is wide enough for N full-scale samples, so the sum cannot wrap.
    assign sum_next = acc_p0 + ACC_W'(sample);
    assign min_next = min_u(min_p0, sample);
    assign max_next = max_u(max_p0, sample);
    assign avg_next = avg_trunc(sum_next);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en_i)  state_q <= RUN;
                RUN:     if (!en_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- window stage: accumulate samples, restart on the Nth or on entry to RUN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            min_p0 <= '0;
            max_p0 <= '0;
        end else if (start || last) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            min_p0 <= MIN_INIT;
            max_p0 <= MAX_INIT;
        end else if (take) begin
            acc_p0 <= sum_next;
            cnt_p0 <= cnt_p0 + CNT_ONE;
            min_p0 <= min_next;
            max_p0 <= max_next;
        end
    end

    // ---- result stage: single-entry output register with valid/ready handshake
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            avg_o  <= '0;
            min_o  <= '0;
            max_o  <= '0;
            over_o <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (last) begin
            avg_o  <= avg_next;
            min_o  <= min_next;
            max_o  <= max_next;
            over_o <= (avg_next >= THRESH);
            vld_p1 <= 1'b1;
        end else if (xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    // A result is lost only when it is overwritten without having been taken.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ovr_p1 <= 1'b0;
        end else if (start) begin
            ovr_p1 <= 1'b0;
        end else if (last && vld_p1 && !avg_ready_i) begin
            ovr_p1 <= 1'b1;
        end
    end

    assign avg_valid_o = vld_p1;
    assign overrun_o   = ovr_p1;

endmodule

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning the window is N = 2^LOG2_N samples; legal range is 1..8.
REQ-002 SHALL have parameter THRESH, default 12'hC00, meaning the over-threshold compare level on the average.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, which is the XADC DCLK domain.
REQ-004 SHALL have port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port en_i, input, 1 bit: acquisition enable.
REQ-006 SHALL have port drdy_i, input, 1 bit: XADC DRP data-ready pulse.
REQ-007 SHALL have port data_i, input, 16 bits: XADC do_out word; the sample is in bits [15:4].
REQ-008 SHALL have port avg_o, output, 12 bits: window average.
REQ-009 SHALL have port min_o, output, 12 bits: window minimum.
REQ-010 SHALL have port max_o, output, 12 bits: window maximum.
REQ-011 SHALL have port over_o, output, 1 bit: set when avg_o >= THRESH.
REQ-012 SHALL have port avg_valid_o, output, 1 bit: result valid.
REQ-013 SHALL have port avg_ready_i, input, 1 bit: consumer ready.
REQ-014 SHALL have port overrun_o, output, 1 bit: sticky flag indicating a result was lost.

Function
REQ-015 SHALL implement an FSM with states IDLE and RUN; IDLE->RUN when en_i=1; RUN->IDLE when en_i=0.
REQ-016 On IDLE->RUN, SHALL clear the accumulator, the sample count, min (to 12'hFFF) and max (to 12'h000).
REQ-017 In RUN, a sample SHALL be taken only in cycles where drdy_i=1; data_i[3:0] SHALL be ignored.
REQ-018 The accumulator SHALL be 12+LOG2_N bits wide and SHALL never overflow.
REQ-019 On the Nth sample of a window, SHALL compute avg = (acc + sample) >> LOG2_N, truncated with no rounding, and SHALL compute min/max including that sample.
REQ-020 The result (avg_o, min_o, max_o, over_o) SHALL load into the output register, with avg_valid_o=1, on the clock edge of the Nth drdy_i; it is visible in the following cycle, giving one-cycle latency.
REQ-021 On the same edge, SHALL restart the next window (accumulator, count, min, max reset) so no sample is dropped between windows.
REQ-022 The output register SHALL hold its value while avg_valid_o=1 and avg_ready_i=0.
REQ-023 A transfer occurs when avg_valid_o=1 and avg_ready_i=1; avg_valid_o SHALL drop on the next edge unless a new result loads on that same edge.
REQ-024 If a new result loads while avg_valid_o=1 with no transfer in that cycle, SHALL overwrite the result, keep avg_valid_o=1, and set overrun_o=1.
REQ-025 If a new result loads in the same cycle as a transfer, SHALL load the new result, keep avg_valid_o=1, and leave overrun_o unchanged.
REQ-026 If en_i=0 mid-window, SHALL discard the partial window; a pending result SHALL remain valid until transferred.
REQ-027 overrun_o SHALL clear only on reset or on the IDLE->RUN transition.
REQ-028 In IDLE, drdy_i SHALL be ignored.

Reset
REQ-029 While reset_ni=0, SHALL asynchronously force: FSM=IDLE, accumulator=0, count=0, avg_o=0, min_o=0, max_o=0, over_o=0, avg_valid_o=0, overrun_o=0.
REQ-030 Reset asserted mid-window SHALL discard all state, with no result emitted.
REQ-031 Reset release SHALL take effect synchronously to clk_i; the first sample may be accepted no earlier than the second edge after release.

Verification
REQ-032 SHALL verify basic averaging: LOG2_N=2, en_i=1, drdy_i pulses with data_i=16'h1000, 16'h2000, 16'h3000, 16'h4000, avg_ready_i=1 -> avg_o=12'h280, min_o=12'h100, max_o=12'h400, over_o=0, avg_valid_o high for 1 cycle.
REQ-033 SHALL verify the threshold: LOG2_N=2, four samples of 16'hC000 -> avg_o=12'hC00, over_o=1; four samples of 16'hBFF0 -> over_o=0.
REQ-034 SHALL verify backpressure and overrun: avg_ready_i=0 across two windows -> avg_valid_o held, overrun_o=1, avg_o equal to the second window's average; then avg_ready_i=1 -> avg_valid_o=0 next cycle.
REQ-035 SHALL verify a simultaneous event: transfer in the same cycle the next result loads -> avg_valid_o stays 1, new value presented, overrun_o=0.
REQ-036 SHALL verify abort: en_i=0 after 2 of 4 samples, then en_i=1 and 4 samples of 16'h0010 -> avg_o=12'h001, with no contribution from the aborted samples.
REQ-037 SHALL verify mid-window reset: reset_ni pulsed low after 3 samples -> all outputs 0 immediately, and no result appears until 4 fresh samples are taken.
